// File: rtl/fifo_arb_pkg.sv
// Shared types and sizing helpers for the FIFO write arbiter and its
// round-robin picker (also usable by the read-side scheduler).
package fifo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int cnt_width(input int max_beats);
    return $clog2(max_beats + 1);
  endfunction

  // Returns the position of the highest set bit; callers pass a one-hot value.
  function automatic int onehot_to_idx(input logic [31:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Combinational round-robin picker: first valid bit at or above rr_ptr_i,
// wrapping modulo N (N need not be a power of two).
module fifo_rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] rr_ptr_i,
  output logic [N-1:0]  pick_o,
  output logic          any_valid_o
);

  int            idx;
  logic [IW-1:0] sel;
  logic          found;

  always_comb begin
    pick_o = '0;
    found  = 1'b0;
    idx    = 0;
    sel    = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(rr_ptr_i) + k;
      if (idx >= N) idx = idx - N;
      sel = IW'(idx);
      if (!found && valid_i[sel]) begin
        pick_o[sel] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  assign any_valid_o = |valid_i;

endmodule

// File: rtl/fifo_write_arbiter.sv
// Packet-granular round-robin arbiter sharing the async FIFO write port
// among NREQ wclk-domain requesters, with a maximum packet length guard.
//
// state | meaning
// IDLE  | no owner; arbitrate among valid requesters, nothing written
// BUSY  | grant_q owns the write port until its last (or forced) beat
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DSIZE     = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic                       wclk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*DSIZE-1:0]      req_data,
  input  logic [NREQ-1:0]            req_last,
  output logic [NREQ-1:0]            req_ready,
  input  logic                       fifo_full,
  output logic                       fifo_write,
  output logic [DSIZE-1:0]           fifo_wdata,
  output logic [NREQ-1:0]            grant,
  output logic                       busy,
  input  logic                       err_clr,
  output logic                       err_overlen,
  output logic [idx_width(NREQ)-1:0] err_src
);

  localparam int IW = idx_width(NREQ);
  localparam int CW = cnt_width(MAX_BEATS);

  arb_state_e    state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic          err_overlen_q, err_overlen_d;
  logic [IW-1:0] err_src_q, err_src_d;

  logic [NREQ-1:0] pick;
  logic          any_valid;
  logic [IW-1:0] owner;
  logic          own_valid, own_last, acc, at_max;

  fifo_rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .valid_i     (req_valid),
    .rr_ptr_i    (rr_ptr_q),
    .pick_o      (pick),
    .any_valid_o (any_valid)
  );

  assign owner     = IW'(onehot_to_idx(32'(grant_q)));
  assign own_valid = |(req_valid & grant_q);
  assign own_last  = |(req_last & grant_q);
  assign busy      = (state_q == BUSY);
  assign acc       = busy & own_valid & ~fifo_full;
  assign at_max    = (beat_cnt_q == CW'(MAX_BEATS - 1));

  assign fifo_write = acc;
  assign req_ready  = busy ? (grant_q & {NREQ{~fifo_full}}) : '0;
  assign grant      = grant_q;
  assign err_overlen = err_overlen_q;
  assign err_src    = err_src_q;

  always_comb begin
    fifo_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) fifo_wdata = req_data[i*DSIZE +: DSIZE];
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_ptr_d      = rr_ptr_q;
    beat_cnt_d    = beat_cnt_q;
    err_overlen_d = err_overlen_q & ~err_clr;
    err_src_d     = err_src_q;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          grant_d = pick;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (acc) begin
          if (own_last || at_max) begin
            state_d    = IDLE;
            grant_d    = '0;
            beat_cnt_d = '0;
            rr_ptr_d   = (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
            // Forced release: the set wins over a simultaneous err_clr.
            if (!own_last) begin
              err_overlen_d = 1'b1;
              err_src_d     = owner;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wclk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      rr_ptr_q      <= '0;
      beat_cnt_q    <= '0;
      err_overlen_q <= 1'b0;
      err_src_q     <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      rr_ptr_q      <= rr_ptr_d;
      beat_cnt_q    <= beat_cnt_d;
      err_overlen_q <= err_overlen_d;
      err_src_q     <= err_src_d;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter: per-requester packet queues
// drive the inputs, a scoreboard queue holds the expected FIFO write order.
module tb_fifo_write_arbiter;

  logic        wclk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        fifo_write;
  logic [7:0]  fifo_wdata;
  logic [3:0]  grant;
  logic        busy;
  logic        err_clr;
  logic        err_overlen;
  logic [1:0]  err_src;

  fifo_write_arbiter #(.NREQ(4), .DSIZE(8), .MAX_BEATS(16)) dut (
    .wclk        (wclk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .fifo_full   (fifo_full),
    .fifo_write  (fifo_write),
    .fifo_wdata  (fifo_wdata),
    .grant       (grant),
    .busy        (busy),
    .err_clr     (err_clr),
    .err_overlen (err_overlen),
    .err_src     (err_src)
  );

  always #5 wclk = ~wclk;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;

  logic [8:0] pq[4][$];
  logic [7:0] exp_q[$];
  logic [3:0] glog[$];
  logic [3:0] hold = '0;
  logic [3:0] acc_r = '0;
  logic [3:0] prev_grant = '0;
  logic       bubble_pend = 1'b0;

  logic [3:0] s_grant, s_ready;
  logic       s_busy, s_write, s_err;
  logic [1:0] s_src;

  function automatic logic [7:0] mkd(input int id, input int seq);
    return {id[1:0], seq[5:0]};
  endfunction

  task automatic enq(input int id, input int seq, input bit last);
    pq[id].push_back({last, mkd(id, seq)});
  endtask

  task automatic expect_beat(input int id, input int seq);
    exp_q.push_back(mkd(id, seq));
  endtask

  task automatic drive_update();
    logic [8:0] tmp;
    for (int i = 0; i < 4; i++) begin
      if (acc_r[i] && pq[i].size() > 0) tmp = pq[i].pop_front();
      if (pq[i].size() > 0 && !hold[i]) begin
        tmp = pq[i][0];
        req_valid[i] = 1'b1;
        req_data[i*8 +: 8] = tmp[7:0];
        req_last[i] = tmp[8];
      end else begin
        req_valid[i] = 1'b0;
        req_data[i*8 +: 8] = 8'h00;
        req_last[i] = 1'b0;
      end
    end
    acc_r = '0;
  endtask

  // One clock: sample and score at the falling edge, drive after the rising edge.
  task automatic cycle();
    logic [7:0] e;
    @(negedge wclk);
    s_grant = grant; s_busy = busy; s_write = fifo_write;
    s_ready = req_ready; s_err = err_overlen; s_src = err_src;
    if (!rst) begin
      if (fifo_write) begin
        wr_cnt++;
        checks++;
        if (fifo_full) begin
          errors++; $display("FAIL write_while_full fifo_write=1 with fifo_full=1");
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL unexpected_write got %h expected none", fifo_wdata);
        end else begin
          e = exp_q.pop_front();
          if (fifo_wdata !== e) begin
            errors++; $display("FAIL wdata got %h expected %h", fifo_wdata, e);
          end
        end
      end
      if (bubble_pend) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++; $display("FAIL bubble busy got %b expected 0", busy);
        end
      end
      checks++;
      if (!$onehot0(grant)) begin
        errors++; $display("FAIL grant_onehot got %b expected one-hot or 0", grant);
      end
      bubble_pend = fifo_write && (|(grant & req_last));
      if (grant !== prev_grant && grant != 4'b0) glog.push_back(grant);
      prev_grant = grant;
    end
    acc_r = req_valid & req_ready;
    @(posedge wclk);
    #1;
    drive_update();
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || s_busy || pq[0].size() != 0 || pq[1].size() != 0 ||
            pq[2].size() != 0 || pq[3].size() != 0) && n < budget) begin
      cycle();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++; $display("FAIL idle_timeout pending %0d expected 0", exp_q.size());
    end
  endtask

  task automatic wait_writes(input int cnt, input int budget);
    int base = wr_cnt;
    int n = 0;
    while (wr_cnt - base < cnt && n < budget) begin
      cycle();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++; $display("FAIL write_timeout got %0d writes expected %0d", wr_cnt - base, cnt);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) pq[i].delete();
    exp_q.delete();
    glog.delete();
    acc_r = '0; hold = '0; fifo_full = 1'b0; err_clr = 1'b0;
    drive_update();
    @(posedge wclk); #1;
    rst = 1'b0;
    prev_grant = '0; bubble_pend = 1'b0; s_busy = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (grant !== 4'b0 || busy !== 1'b0 || fifo_write !== 1'b0 || req_ready !== 4'b0) begin
      errors++;
      $display("FAIL reset_outputs got grant=%b busy=%b wr=%b rdy=%b expected 0", grant, busy, fifo_write, req_ready);
    end
    checks++;
    if (err_overlen !== 1'b0 || err_src !== 2'd0) begin
      errors++; $display("FAIL reset_err got %b/%0d expected 0/0", err_overlen, err_src);
    end
  endtask

  task automatic test_single_packet();
    logic [3:0] eg[3];
    glog.delete();
    pq[0].push_back({1'b0, 8'h11});
    pq[0].push_back({1'b0, 8'h22});
    pq[0].push_back({1'b1, 8'h33});
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    drive_update();
    cycle();
    checks++;
    if (s_grant !== 4'b0000 || s_write !== 1'b0) begin
      errors++; $display("FAIL arb_latency got grant=%b wr=%b expected 0000/0", s_grant, s_write);
    end
    cycle();
    checks++;
    if (s_grant !== 4'b0001 || s_write !== 1'b1) begin
      errors++; $display("FAIL first_grant got grant=%b wr=%b expected 0001/1", s_grant, s_write);
    end
    wait_idle(40);
    // rr_ptr must now be 1: requester 1 beats requester 0
    enq(0, 1, 1'b1); enq(1, 1, 1'b1);
    expect_beat(1, 1); expect_beat(0, 1);
    drive_update();
    wait_idle(40);
    eg = '{4'b0001, 4'b0010, 4'b0001};
    checks++;
    if (glog.size() != 3) begin
      errors++; $display("FAIL single_glog_size got %0d expected 3", glog.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (glog[i] !== eg[i]) begin
          errors++; $display("FAIL single_grant[%0d] got %b expected %b", i, glog[i], eg[i]);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] eg[5];
    do_reset();
    for (int p = 0; p < 2; p++) begin
      enq(0, 2*p, 1'b0); enq(0, 2*p+1, 1'b1);
    end
    for (int r = 1; r < 4; r++) begin
      enq(r, 0, 1'b0); enq(r, 1, 1'b1);
    end
    for (int r = 0; r < 4; r++) begin
      expect_beat(r, 0); expect_beat(r, 1);
    end
    expect_beat(0, 2); expect_beat(0, 3);
    drive_update();
    wait_idle(80);
    eg = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    checks++;
    if (glog.size() != 5) begin
      errors++; $display("FAIL rr_glog_size got %0d expected 5", glog.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (glog[i] !== eg[i]) begin
          errors++; $display("FAIL rr_grant[%0d] got %b expected %b", i, glog[i], eg[i]);
        end
      end
    end
  endtask

  task automatic test_fifo_full();
    for (int s = 0; s < 6; s++) begin
      enq(1, s, s == 5); expect_beat(1, s);
    end
    drive_update();
    wait_writes(2, 40);
    fifo_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cycle();
      checks++;
      if (s_write !== 1'b0 || s_ready !== 4'b0000) begin
        errors++; $display("FAIL full_stall[%0d] got wr=%b rdy=%b expected 0/0000", c, s_write, s_ready);
      end
    end
    fifo_full = 1'b0;
    cycle();
    checks++;
    if (s_write !== 1'b1 || s_ready !== 4'b0010) begin
      errors++; $display("FAIL full_resume got wr=%b rdy=%b expected 1/0010", s_write, s_ready);
    end
    wait_idle(40);
  endtask

  task automatic test_overlen();
    logic [3:0] eg[3];
    glog.delete();
    for (int s = 0; s < 17; s++) enq(2, s, s == 16);
    enq(3, 0, 1'b1);
    for (int s = 0; s < 16; s++) expect_beat(2, s);
    expect_beat(3, 0);
    expect_beat(2, 16);
    drive_update();
    wait_writes(15, 60);
    checks++;
    if (s_err !== 1'b0) begin
      errors++; $display("FAIL overlen_early got %b expected 0", s_err);
    end
    wait_idle(80);
    checks++;
    if (s_err !== 1'b1 || s_src !== 2'd2) begin
      errors++; $display("FAIL overlen_flag got %b/%0d expected 1/2", s_err, s_src);
    end
    eg = '{4'b0100, 4'b1000, 4'b0100};
    checks++;
    if (glog.size() != 3) begin
      errors++; $display("FAIL overlen_glog_size got %0d expected 3", glog.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (glog[i] !== eg[i]) begin
          errors++; $display("FAIL overlen_grant[%0d] got %b expected %b", i, glog[i], eg[i]);
        end
      end
    end
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    cycle();
    checks++;
    if (s_err !== 1'b0) begin
      errors++; $display("FAIL err_clr got %b expected 0", s_err);
    end
  endtask

  task automatic test_owner_stall();
    logic [3:0] eg[2];
    glog.delete();
    for (int s = 0; s < 4; s++) begin
      enq(3, s, s == 3); expect_beat(3, s);
    end
    enq(1, 0, 1'b0); enq(1, 1, 1'b1);
    expect_beat(1, 0); expect_beat(1, 1);
    drive_update();
    wait_writes(2, 40);
    hold[3] = 1'b1;
    drive_update();
    for (int c = 0; c < 3; c++) begin
      cycle();
      checks++;
      if (s_write !== 1'b0 || s_grant !== 4'b1000) begin
        errors++; $display("FAIL owner_stall[%0d] got wr=%b grant=%b expected 0/1000", c, s_write, s_grant);
      end
    end
    hold[3] = 1'b0;
    drive_update();
    wait_idle(40);
    eg = '{4'b1000, 4'b0010};
    checks++;
    if (glog.size() != 2 || glog[0] !== eg[0] || glog[1] !== eg[1]) begin
      errors++; $display("FAIL stall_grants got %0d entries expected 1000 then 0010", glog.size());
    end
  endtask

  task automatic test_reset_midpacket();
    logic [3:0] eg[2];
    for (int s = 0; s < 5; s++) begin
      enq(3, s, s == 4); expect_beat(3, s);
    end
    drive_update();
    wait_writes(2, 40);
    rst = 1'b1;
    #1;
    checks++;
    if (grant !== 4'b0 || busy !== 1'b0 || fifo_write !== 1'b0) begin
      errors++; $display("FAIL async_reset got grant=%b busy=%b wr=%b expected 0000/0/0", grant, busy, fifo_write);
    end
    for (int i = 0; i < 4; i++) pq[i].delete();
    exp_q.delete(); glog.delete(); acc_r = '0;
    drive_update();
    @(posedge wclk); #1;
    rst = 1'b0;
    prev_grant = '0; bubble_pend = 1'b0; s_busy = 1'b0;
    // With rr_ptr back at 0, requester 1 wins over requester 2.
    enq(1, 7, 1'b1); enq(2, 7, 1'b1);
    expect_beat(1, 7); expect_beat(2, 7);
    drive_update();
    wait_idle(40);
    eg = '{4'b0010, 4'b0100};
    checks++;
    if (glog.size() != 2 || glog[0] !== eg[0] || glog[1] !== eg[1]) begin
      errors++; $display("FAIL post_reset_rr got %0d entries expected 0010 then 0100", glog.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0; req_data = '0; req_last = '0;
    fifo_full = 1'b0; err_clr = 1'b0;
    s_busy = 1'b0;
    repeat (2) @(posedge wclk);
    #1;
    test_reset();
    rst = 1'b0;
    test_single_packet();
    test_round_robin();
    test_fifo_full();
    test_overlen();
    test_owner_stall();
    test_reset_midpacket();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
Write-side arbiter that shares the single write port of the async FIFO among NREQ requesters in the wclk domain. It grants one requester at a time for a whole packet, delimited by a last flag, using round-robin fairness between packets. It drives the FIFO write strobe and data and honours the FIFO full flag, so a beat is committed only when the FIFO accepts it. It enforces a maximum packet length and reports violations.

Parameters:
NREQ, 4, number of requesters (>=2)
DSIZE, 8, FIFO data width
MAX_BEATS, 16, maximum beats per packet before forced release (>=2)

Ports:
wclk  input  1  write-domain clock
rst  input  1  asynchronous, active-high reset
req_valid  input  NREQ  per-requester beat valid
req_data  input  NREQ*DSIZE  per-requester beat data; requester i occupies bits [i*DSIZE +: DSIZE]
req_last  input  NREQ  beat is last of packet
req_ready  output  NREQ  beat accepted this cycle when valid&ready
fifo_full  input  1  FIFO full flag (write side, registered)
fifo_write  output  1  FIFO write strobe
fifo_wdata  output  DSIZE  FIFO write data
grant  output  NREQ  one-hot current owner, registered; 0 when idle
busy  output  1  packet in progress (state==BUSY)
err_clr  input  1  clears error flags
err_overlen  output  1  sticky: a packet hit MAX_BEATS without last
err_src  output  clog2(NREQ)  index of requester that caused the latest err_overlen

Behaviour:
- Reset: state IDLE, grant=0, rr_ptr=0, beat_cnt=0, err_overlen=0, err_src=0. Outputs req_ready=0 and fifo_write=0.
- States: IDLE, BUSY.
- IDLE: if any req_valid, pick the first set bit scanning from rr_ptr upward, modulo NREQ. Register grant (one-hot) and go to BUSY. Nothing is written in IDLE. Arbitration latency is 1 cycle.
- BUSY, owner g:
  - fifo_write = req_valid[g] & ~fifo_full
  - fifo_wdata = req_data[g]
  - req_ready[g] = ~fifo_full; all other req_ready bits are 0.
  - These outputs are combinational from req_valid, fifo_full and the registered grant.
- Beat accepted (acc) = req_valid[g] & ~fifo_full. beat_cnt increments on each acc.
- Accepted beat with req_last=1: return to IDLE, grant=0, beat_cnt=0, rr_ptr=(g+1) mod NREQ. There is one bubble cycle between packets.
- Accepted beat with req_last=0 and beat_cnt==MAX_BEATS-1: forced release.
  - Same transition as a last beat.
  - err_overlen<=1 and err_src<=g.
- req_valid[g] low mid-packet: grant is held indefinitely, no write and no count. Other requesters are blocked; the packet is never interleaved.
- fifo_full high: no write and no count. req_data is held by the requester; state does not change. Full deasserting resumes writing in the same cycle.
- fifo_write is never asserted while fifo_full=1. The FIFO pointer logic additionally gates on full; the arbiter must not rely on that gating.
- err_clr: clears err_overlen. If a forced release occurs in the same cycle, the set wins.
- Non-owners' valids are ignored while BUSY. Owner changes only through IDLE.
- rst asserted mid-packet: immediate return to reset values. The partial packet is abandoned, and requester re-sends are the requester's responsibility.
- Width rules:
  - beat_cnt is clog2(MAX_BEATS+1) bits and never wraps.
  - rr_ptr is clog2(NREQ) bits; wrap NREQ-1 -> 0 is explicit (NREQ need not be a power of 2).

Decomposition:
- Shared package fifo_arb_pkg:
  - state enum {IDLE, BUSY}
  - IDXW = clog2(NREQ) and CNTW = clog2(MAX_BEATS+1) helper functions
  - onehot-to-index function
- Sub-module fifo_rr_pick, combinational:
  - inputs: valid vector and rr_ptr
  - outputs: one-hot pick and any_valid
  - reusable by the read-side scheduler

Test Plan:
- Reset, then req_valid=4'b0001 with a 3-beat packet (data 0x11,0x22,0x33, last on 0x33) -> grant=0001 one cycle later; three fifo_write pulses with those data in order; busy falls; rr_ptr=1.
- All four valid continuously, 2-beat packets each -> grant sequence 0001,0010,0100,1000,0001; one idle bubble between packets; no beat interleaving.
- fifo_full forced high for 5 cycles mid-packet -> fifo_write=0 and req_ready=0 for exactly those cycles; beat_cnt frozen; resumes with the held data, no loss or duplication.
- Requester 2 sends 17 beats without last (MAX_BEATS=16) -> release after the 16th accepted beat; err_overlen=1, err_src=2; next grant goes to requester 3; err_clr clears the flag.
- Owner drops req_valid for 3 cycles mid-packet while requester 1 is valid -> grant unchanged, no writes from requester 1 until the owner's last beat.
- rst asserted mid-packet -> grant=0, busy=0, fifo_write=0 immediately (asynchronous); after release, arbitration restarts from rr_ptr=0.
